vga_timing_monitor: RTL

Receive-side counterpart of `vga_controller`. Consumes the generated `hs`, `vs`, `blank` and `pixel_clk` in the 50 MHz domain and rebuilds the pixel position from the sync stream alone. Measures line and frame lengths, and reports lock and timing errors. Sits beside `vga_controller` in the top level, feeding on-board debug (LEDR/HEX) and simulation self-checks.

---
 rtl/vga_timing_monitor.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/vga_timing_monitor.sv
// Receive-side VGA timing monitor: rebuilds pixel position from hs/vs/blank, measures line/frame length, reports lock and errors.
// Optional error counter is built when VGA_MON_ERRCNT_EN is defined; otherwise err_count is tied to 0.
module vga_timing_monitor #(
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned LOCK_FRAMES = 2,
    parameter int unsigned WD_LIMIT    = 1600
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       pixel_clk,
    input  logic       hs,
    input  logic       vs,
    input  logic       blank,
    output logic [9:0] RecX,
    output logic [9:0] RecY,
    output logic       rec_valid,
    output logic [9:0] line_len,
    output logic [9:0] frame_lines,
    output logic       locked,
    output logic       err_sticky,
    output logic [7:0] err_count
);

    localparam int unsigned CW   = 10;
    localparam int unsigned GW   = 4;
    localparam int unsigned WD_W = $clog2(WD_LIMIT + 1);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    state_t          state, state_nx;
    logic [GW-1:0]   good, good_nx, good_inc;
    logic            pixel_clk_q, hs_q, vs_q;
    logic [CW-1:0]   hcnt, vcnt, ax, ay;
    logic            line_vis, line_bad;
    logic [WD_W-1:0] wd, wd_inc;

    logic            tick, hs_fall, vs_fall, vis;
    logic [CW:0]     hcnt_inc;
    logic [CW-1:0]   line_len_c, vcnt_end, ax_eff, ay_eff;
    logic            hbad, bad_end, frame_good, wd_fire, lose, err_evt;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    // Tick/edge detection and the values each counter takes on this tick
    always_comb begin
        tick       = pixel_clk & ~pixel_clk_q;
        hs_fall    = tick & hs_q & ~hs;
        vs_fall    = tick & vs_q & ~vs;
        vis        = tick & blank;
        hcnt_inc   = {1'b0, hcnt} + (CW+1)'(1);
        line_len_c = hcnt_inc[CW] ? {CW{1'b1}} : hcnt_inc[CW-1:0];
        hbad       = hcnt_inc != (CW+1)'(H_TOTAL);
        // A coinciding hs edge closes its line into the ending frame first
        vcnt_end   = hs_fall ? sat_inc(vcnt) : vcnt;
        bad_end    = line_bad | (hs_fall & hbad);
        frame_good = (vcnt_end == CW'(V_TOTAL)) & ~bad_end;
        ax_eff     = hs_fall ? '0 : ax;
        ay_eff     = vs_fall ? '0 : ((hs_fall & line_vis) ? sat_inc(ay) : ay);
        wd_inc     = wd + WD_W'(1);
        wd_fire    = tick & ~hs_fall & (wd_inc == WD_W'(WD_LIMIT));
        lose       = (state == LOCKED) & ((hs_fall & hbad) | (vs_fall & ~frame_good));
        err_evt    = lose | (wd_fire & (state != SEARCH));
        good_inc   = good + GW'(1);
    end

    // Lock acquisition; watchdog overrides every other transition
    always_comb begin
        state_nx = state;
        good_nx  = good;
        case (state)
            SEARCH: begin
                if (vs_fall) begin
                    state_nx = ACQUIRE;
                    good_nx  = '0;
                end
            end
            ACQUIRE: begin
                if (vs_fall) begin
                    if (!frame_good) begin
                        good_nx = '0;
                    end else if (good_inc == GW'(LOCK_FRAMES)) begin
                        state_nx = LOCKED;
                        good_nx  = '0;
                    end else begin
                        good_nx = good_inc;
                    end
                end
            end
            LOCKED: begin
                if (lose) begin
                    state_nx = SEARCH;
                end
            end
            default: state_nx = SEARCH;
        endcase
        if (wd_fire) begin
            state_nx = SEARCH;
            good_nx  = '0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= SEARCH;
            good        <= '0;
            pixel_clk_q <= 1'b0;
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            hcnt        <= '0;
            vcnt        <= '0;
            ax          <= '0;
            ay          <= '0;
            line_vis    <= 1'b0;
            line_bad    <= 1'b0;
            wd          <= '0;
            RecX        <= '0;
            RecY        <= '0;
            rec_valid   <= 1'b0;
            line_len    <= '0;
            frame_lines <= '0;
            locked      <= 1'b0;
            err_sticky  <= 1'b0;
        end else begin
            pixel_clk_q <= pixel_clk;
            rec_valid   <= vis;
            state       <= state_nx;
            good        <= good_nx;
            locked      <= (state_nx == LOCKED);
            if (tick) begin
                hs_q     <= hs;
                vs_q     <= vs;
                hcnt     <= hs_fall ? '0 : sat_inc(hcnt);
                wd       <= (hs_fall | wd_fire) ? '0 : wd_inc;
                ax       <= blank ? sat_inc(ax_eff) : ax_eff;
                ay       <= ay_eff;
                line_vis <= hs_fall ? blank : (line_vis | blank);
                vcnt     <= vs_fall ? '0 : vcnt_end;
                line_bad <= vs_fall ? 1'b0 : bad_end;
                if (blank) begin
                    RecX <= ax_eff;
                    RecY <= ay_eff;
                end
                if (hs_fall) begin
                    line_len <= line_len_c;
                end
                if (vs_fall) begin
                    frame_lines <= vcnt_end;
                end
                if (err_evt) begin
                    err_sticky <= 1'b1;
                end
            end
        end
    end

`ifdef VGA_MON_ERRCNT_EN
    // Saturating count of lock losses and watchdog events
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            err_count <= '0;
        end else if (err_evt && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`else
    assign err_count = '0;
`endif

endmodule
